// File: rtl/divn_pkg.sv
// Shared definitions for the divide-by-N counter controller.
package divn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  localparam logic [3:0] BCD_MAX  = 4'd9;
  localparam logic [7:0] DIVN_MIN = 8'd2;

endpackage

// File: rtl/divn_sub2.sv
// Computes N-2 in binary or two-digit BCD and flags divisors the counter cannot realise.
module divn_sub2
  import divn_pkg::*;
(
  input  logic [7:0] value,
  input  logic       bin_dec,
  output logic [7:0] result,
  output logic       valid
);

  logic [3:0] w_hi;
  logic [3:0] w_lo;

  assign w_hi = value[7:4];
  assign w_lo = value[3:0];

  // BCD borrows from the high digit when the low digit is below 2.
  always_comb begin
    result = value - DIVN_MIN;
    if (!bin_dec)
      result = (w_lo >= 4'd2) ? {w_hi, w_lo - 4'd2} : {w_hi - 4'd1, w_lo + 4'd8};
  end

  assign valid = (value >= DIVN_MIN) &&
                 (bin_dec || ((w_hi <= BCD_MAX) && (w_lo <= BCD_MAX)));

endmodule

// File: rtl/divn_ctrl.sv
// Controller for a cascaded pair of 4-bit presettable counters producing one tick every N cycles.
module divn_ctrl
  import divn_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic [7:0] divisor,
  input  logic       bin_dec,
  input  logic       repeat_mode,
  input  logic       cnt_cout_n,
  output logic [7:0] cnt_preset,
  output logic       cnt_preset_en,
  output logic       cnt_cin_n,
  output logic       cnt_up_down,
  output logic       cnt_bin_dec,
  output logic       busy,
  output logic       tick,
  output logic       err
);

  state_t     r_state;
  state_t     w_state_nxt;
  logic       r_repeat;
  logic [7:0] w_sub_result;
  logic       w_sub_valid;
  logic       w_accept;
  logic       w_reject;
  logic       w_period_end;

  divn_sub2 u_sub2 (
    .value   (divisor),
    .bin_dec (bin_dec),
    .result  (w_sub_result),
    .valid   (w_sub_valid)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_accept     = 1'b0;
    w_reject     = 1'b0;
    w_period_end = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (start) begin
          if (w_sub_valid) begin
            w_accept    = 1'b1;
            w_state_nxt = ST_LOAD;
          end else begin
            w_reject = 1'b1;
          end
        end
      end
      ST_LOAD: w_state_nxt = stop ? ST_IDLE : ST_RUN;
      ST_RUN: begin
        // stop wins over a terminal count in the same cycle, so no tick is issued.
        if (stop) begin
          w_state_nxt = ST_IDLE;
        end else if (!cnt_cout_n) begin
          w_period_end = 1'b1;
          w_state_nxt  = r_repeat ? ST_LOAD : ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_repeat      <= 1'b0;
      cnt_preset    <= 8'h00;
      cnt_preset_en <= 1'b0;
      cnt_cin_n     <= 1'b1;
      cnt_bin_dec   <= 1'b1;
      busy          <= 1'b0;
      tick          <= 1'b0;
      err           <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      cnt_preset_en <= (w_state_nxt == ST_LOAD);
      cnt_cin_n     <= (w_state_nxt != ST_RUN);
      busy          <= (w_state_nxt != ST_IDLE);
      tick          <= w_period_end;
      if (w_accept) begin
        cnt_preset  <= w_sub_result;
        cnt_bin_dec <= bin_dec;
        r_repeat    <= repeat_mode;
        err         <= 1'b0;
      end else if (w_reject) begin
        err <= 1'b1;
      end
    end
  end

  assign cnt_up_down = 1'b0;

endmodule

// File: doc/divn_ctrl.md
DIVN_CTRL -- requirements
Module: divn_ctrl

Interface
REQ-001 Port list SHALL be as follows, clock and reset first.
  clk  input  1  sole clock, rising-edge.
  rst  input  1  synchronous, active-high reset.
  start  input  1  request to begin dividing; sampled in IDLE only.
  stop  input  1  abort request; sampled in any non-IDLE state.
  divisor  input  8  N; two BCD digits when bin_dec=0, 8-bit binary when bin_dec=1.
  bin_dec  input  1  1=binary, 0=decimal; latched with divisor.
  repeat  input  1  1=continuous, 0=one-shot; latched with divisor.
  cnt_cout_n  input  1  active-low terminal count from the most-significant counter stage.
  cnt_preset  output  8  preload value to the two 4-bit counter stages, [7:4] high digit.
  cnt_preset_en  output  1  counter preload strobe, active-high.
  cnt_cin_n  output  1  counter count-enable to the least-significant stage, active-low.
  cnt_up_down  output  1  counter direction; tied 0 (down).
  cnt_bin_dec  output  1  counter mode; equals latched bin_dec.
  busy  output  1  high in LOAD and RUN.
  tick  output  1  one-cycle pulse per completed period.
  err  output  1  sticky flag for a rejected start.
REQ-002 The block SHALL use one clock; reset SHALL be synchronous and active-high on port rst.
REQ-003 All outputs SHALL be registered, except cnt_up_down (constant 0).

Function
REQ-004 The FSM SHALL have three states: IDLE, LOAD and RUN.
REQ-005 In IDLE, start=1 with a valid divisor SHALL latch divisor, bin_dec and repeat, clear err and enter LOAD.
REQ-006 A divisor SHALL be valid iff N>=2 and, when bin_dec=0, both nibbles are <=9.
REQ-007 In IDLE, start=1 with an invalid divisor SHALL set err, remain in IDLE and leave cnt_preset_en at 0.
REQ-008 start SHALL be ignored outside IDLE.
REQ-009 cnt_preset SHALL equal N-2, computed in the latched radix; BCD SHALL borrow across digits (8'h10 -> 8'h08, 8'h02 -> 8'h00).
REQ-010 LOAD SHALL last exactly one cycle with cnt_preset_en=1 and cnt_cin_n=1, then go to RUN.
REQ-011 In RUN, cnt_cin_n SHALL be 0 and cnt_preset_en SHALL be 0.
REQ-012 In RUN, sampling cnt_cout_n=0 at a clock edge SHALL set tick=1 for the following cycle.
REQ-013 On that same edge, the next state SHALL be LOAD if repeat=1, else IDLE.
REQ-014 Period SHALL be exactly N cycles: 1 LOAD cycle plus (N-2)+1 RUN cycles.
REQ-015 In repeat mode, tick SHALL coincide with the reload cycle.
REQ-016 First tick SHALL occur N+1 cycles after the cycle in which start was sampled.
REQ-017 stop=1 in LOAD or RUN SHALL go to IDLE with cnt_cin_n=1 and cnt_preset_en=0 next cycle, and no tick.
REQ-018 stop SHALL take priority over a simultaneous cnt_cout_n=0.
REQ-019 cnt_cout_n SHALL be ignored outside RUN.
REQ-020 err SHALL stay set until the next accepted start or rst.

Reset
REQ-021 rst SHALL force IDLE and take priority over start and stop.
REQ-022 Reset values SHALL be: cnt_preset=8'h00, cnt_preset_en=0, cnt_cin_n=1, cnt_bin_dec=1, busy=0, tick=0, err=0.
REQ-023 rst mid-RUN SHALL suppress any pending tick.
REQ-024 The counter stages have no reset; the LOAD state SHALL be the only means of initialising them.

Structure
REQ-025 Package divn_pkg SHALL hold the state encoding, BCD_MAX=9 and DIVN_MIN=2.
REQ-026 The N-2 subtraction and digit validity check SHALL be one combinational sub-module, divn_sub2, with inputs value[7:0] and bin_dec and outputs result[7:0] and valid.

Verification
Bench: two behavioural 4-bit presettable up/down counter stages, cascaded, driven by this block.
REQ-027 Binary repeat: bin_dec=1, repeat=1, divisor=8'h05, start at cycle t -> cnt_preset=8'h03, ticks at t+6, t+11, t+16.
REQ-028 BCD repeat: bin_dec=0, divisor=8'h10 -> cnt_preset=8'h08, tick every 10 cycles, never cnt_preset_en during RUN.
REQ-029 One-shot: repeat=0, divisor=8'h02 -> cnt_preset=8'h00, single tick at t+3, busy=0 from t+3 onward, no further ticks.
REQ-030 Invalid divisor: divisor=8'h01, then bin_dec=0 with divisor=8'h1A -> err=1, busy=0, cnt_preset_en never 1; a following valid start clears err.
REQ-031 Abort: stop during RUN, also stop in the same cycle as cnt_cout_n=0 -> IDLE and cnt_cin_n=1 next cycle, no tick; repeat the test with rst instead of stop.
REQ-032 Start while busy: start pulses during RUN with a different divisor -> ignored, period unchanged.
